pipe_ctrl: RTL

Central pipeline sequencer for the five-stage core. Merges every stall and flush source into one consistent set of per-stage enable and bubble controls:
- load-use hazard flag from the register bypass/hazard unit;
- multi-cycle MUL/DIV unit handshake;
- IFU and LSU memory wait;
- EX-stage branch/jump redirect.

It sits beside the pipeline registers (PC, IF/ID, ID/EX, EX/LS, LS/WB), drives their write-enable and bubble inputs, and replaces the ad-hoc per-stage enables.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_perf_cnt.sv | 31 +++
 rtl/pipe_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state/cause types for pipe_ctrl.
// CPU_WIDTH normally comes from config.sv; 32 is used when nothing defines it.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
package pipe_pkg;
    localparam int CPU_W = `CPU_WIDTH;
    typedef enum logic [1:0] {RUN, MDU, HOLD} pipe_state_e;
    typedef enum logic [2:0] {C_NONE, C_MEM, C_MDU, C_LDU, C_FETCH} stall_cause_e;
endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: wrapping performance counters, one cause counted per cycle.
module pipe_perf_cnt
    import pipe_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  stall_cause_e     i_cause,
    output logic [CPU_W-1:0] o_cycles,
    output logic [CPU_W-1:0] o_ldu,
    output logic [CPU_W-1:0] o_mdu,
    output logic [CPU_W-1:0] o_mem
);
    logic [CPU_W-1:0] cycles_q, ldu_q, mdu_q, mem_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycles_q <= '0;
            ldu_q    <= '0;
            mdu_q    <= '0;
            mem_q    <= '0;
        end else begin
            cycles_q <= cycles_q + CPU_W'(1);
            ldu_q    <= ldu_q + CPU_W'(i_cause == C_LDU);
            mdu_q    <= mdu_q + CPU_W'(i_cause == C_MDU);
            mem_q    <= mem_q + CPU_W'(i_cause == C_MEM);
        end
    end
    assign o_cycles = cycles_q;
    assign o_ldu    = ldu_q;
    assign o_mdu    = mdu_q;
    assign o_mem    = mem_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges memory, MUL/DIV, load-use, redirect and fetch stalls into stage enables/bubbles.
// Performance counters are built only when PIPE_PERF_EN is defined; otherwise they read 0.
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ldu_hazard,
    input  logic             i_exu_mdu,
    input  logic             i_mdu_done,
    output logic             o_mdu_start,
    input  logic             i_exu_redirect,
    input  logic             i_ifu_ready,
    input  logic             i_lsu_req,
    input  logic             i_lsu_ready,
    output logic             o_pc_wen,
    output logic             o_ifid_wen,
    output logic             o_idex_wen,
    output logic             o_exls_wen,
    output logic             o_lswb_wen,
    output logic             o_ifid_bubble,
    output logic             o_idex_bubble,
    output logic             o_exls_bubble,
    output logic             o_lswb_bubble,
    output logic [CPU_W-1:0] o_perf_cycles,
    output logic [CPU_W-1:0] o_perf_ldu,
    output logic [CPU_W-1:0] o_perf_mdu,
    output logic [CPU_W-1:0] o_perf_mem
);
    pipe_state_e state_q, state_d;
    logic kill_q, kill_d;
    logic mem_stall, mdu_start, mdu_stall, ldu_stall, redir, fetch_stall;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RUN;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end
    // each term is qualified by the absence of every higher-priority term
    always_comb begin
        mem_stall     = i_lsu_req & ~i_lsu_ready;
        mdu_start     = ~i_rst & state_q == RUN & i_exu_mdu & ~mem_stall;
        mdu_stall     = ~mem_stall & (mdu_start | (state_q == MDU & ~i_mdu_done));
        ldu_stall     = ~mem_stall & ~mdu_stall & i_ldu_hazard;
        redir         = ~mem_stall & ~mdu_stall & ~i_ldu_hazard & i_exu_redirect;
        fetch_stall   = ~mem_stall & ~mdu_stall & ~i_ldu_hazard & ~i_exu_redirect & (~i_ifu_ready | kill_q);
        o_mdu_start   = mdu_start;
        o_pc_wen      = ~i_rst & ~(mem_stall | mdu_stall | ldu_stall | fetch_stall);
        o_ifid_wen    = ~i_rst & ~(mem_stall | mdu_stall | ldu_stall);
        o_idex_wen    = ~i_rst & ~(mem_stall | mdu_stall);
        o_exls_wen    = ~i_rst & ~mem_stall;
        o_lswb_wen    = ~i_rst;
        o_ifid_bubble = i_rst | redir | fetch_stall;
        o_idex_bubble = i_rst | ldu_stall | redir;
        o_exls_bubble = i_rst | mdu_stall;
        o_lswb_bubble = i_rst | mem_stall;
        kill_d        = redir ? ~i_ifu_ready : kill_q & ~(fetch_stall & i_ifu_ready);
        state_d       = state_q == RUN ? (mdu_start ? MDU : RUN) :
                        (state_q == MDU & ~i_mdu_done) ? MDU :
                        mem_stall ? HOLD : RUN;
    end
`ifdef PIPE_PERF_EN
    stall_cause_e cause;
    always_comb begin
        cause = mem_stall ? C_MEM :
                (state_q != RUN | mdu_start) ? C_MDU :
                i_ldu_hazard ? C_LDU :
                fetch_stall ? C_FETCH : C_NONE;
    end
    pipe_perf_cnt u_perf (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_cause  (cause),
        .o_cycles (o_perf_cycles),
        .o_ldu    (o_perf_ldu),
        .o_mdu    (o_perf_mdu),
        .o_mem    (o_perf_mem)
    );
`else
    assign o_perf_cycles = '0;
    assign o_perf_ldu    = '0;
    assign o_perf_mdu    = '0;
    assign o_perf_mem    = '0;
`endif
endmodule
